// File: rtl/hilo_muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit_pkg
//   Shared types for the HI/LO multiply/divide unit: the control unit's
//   alu_ctrl codes, the unit's FSM state encoding, the default operand width
//   and a small decode helper for the HI/LO move requests.
// -----------------------------------------------------------------------------
package hilo_muldiv_unit_pkg;

    localparam int DEF_WIDTH = 32;

    // alu_ctrl codes driven by the control unit. Only the HI/LO related codes
    // are acted on here; the rest are listed so that decode sites read clearly.
    typedef enum logic [3:0] {
        ADDac   = 4'd0,
        SUBac   = 4'd1,
        ANDac   = 4'd2,
        ORac    = 4'd3,
        XORac   = 4'd4,
        NORac   = 4'd5,
        SLTac   = 4'd6,
        SLTUac  = 4'd7,
        MULTUac = 4'd8,
        DIVUac  = 4'd9,
        MFHIac  = 4'd10,
        MFLOac  = 4'd11,
        MULTac  = 4'd12,
        DIVac   = 4'd13
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    // True for the two codes that read HI or LO back into the datapath.
    function automatic logic is_mf(input logic [3:0] code);
        return (code == MFHIac) || (code == MFLOac);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// -----------------------------------------------------------------------------
// muldiv_core
//   One combinational iteration of the HI/LO unit's arithmetic, applied to the
//   2*WIDTH-bit accumulator held in hilo_muldiv_unit.
//
//   Multiply (is_div=0): acc = {partial product, remaining multiplier bits}.
//     If the multiplier LSB is set, the multiplicand is added into the upper
//     half; the whole accumulator then shifts right one bit.
//   Divide   (is_div=1): acc = {partial remainder, remaining dividend bits}.
//     The remainder is shifted left pulling in the next dividend bit (a
//     WIDTH+1-bit value), the divisor is trial-subtracted, and the quotient
//     bit shifts in at the bottom. A zero divisor always "fits", which yields
//     an all-ones quotient and the dividend as remainder.
//
// Ports
//   is_div    in   1         select divide step (1) or multiply step (0)
//   acc       in   2*WIDTH   current accumulator
//   operand   in   WIDTH     multiplicand or divisor
//   acc_next  out  2*WIDTH   accumulator after one step
// -----------------------------------------------------------------------------
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   partial;
    logic             fits;
    logic [WIDTH-1:0] diff;

    // NOTE: every always_comb output gets a value on every path (defaults or
    // a full if/else); a missing branch would infer a latch.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);

        partial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        fits    = partial >= {1'b0, operand};
        // When the divisor fits, the true difference is below the divisor,
        // so WIDTH-bit modular subtraction is exact.
        diff    = partial[WIDTH-1:0] - operand;

        if (is_div) begin
            acc_next = {(fits ? diff : partial[WIDTH-1:0]), acc[WIDTH-2:0], fits};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit
//   Multi-cycle HI/LO responder for MULTU / DIVU / MFHI / MFLO requests.
//   Radix-2 shift-add multiply and restoring divide, one bit per clock, WIDTH
//   iterations. Owns the HI/LO registers and drives the HI/LO read-back value
//   for the datapath result mux. stall holds off an MFHI/MFLO that would read
//   HI/LO while an operation is still iterating.
//
//   Optional build macro MULDIV_SIGNED_EN: also accept MULTac/DIVac (signed
//   MULT/DIV). Operands are turned into magnitudes when accepted, run through
//   the unsigned datapath, and the signs are fixed up as HI/LO are written.
//   Without the macro those codes are ignored and no sign logic exists.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request strobe, qualified by alu_ctrl
//   alu_ctrl  in   4      alu_ctrl_t code from the control unit
//   a         in   WIDTH  rs operand (multiplicand / dividend)
//   b         in   WIDTH  rt operand (multiplier / divisor)
//   busy      out  1      iteration in progress
//   done      out  1      one-cycle pulse, HI/LO hold the new result
//   stall     out  1      busy while an MFHI/MFLO is requested
//   hi        out  WIDTH  HI register
//   lo        out  WIDTH  LO register
//   mf_out    out  WIDTH  hi for MFHI, lo for MFLO, else 0
// -----------------------------------------------------------------------------
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_out
);

    // Counts 0..WIDTH-1 during an operation; one spare bit so it never wraps.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    muldiv_state_t      state;
    muldiv_state_t      state_nxt;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand;

    logic               req_mul;
    logic               req_div;
    logic               accept_mul;
    logic               accept_div;
    logic               last_step;
    logic [WIDTH-1:0]   a_load;
    logic [WIDTH-1:0]   b_load;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

`ifdef MULDIV_SIGNED_EN
    logic               req_signed;
    logic               neg_q;      // product / quotient must be negated
    logic               neg_r;      // remainder must be negated
`endif

    // ------------------------------------------------------------------
    // Request decode and operand preparation
    // ------------------------------------------------------------------
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        req_signed = (alu_ctrl == MULTac) || (alu_ctrl == DIVac);
        req_mul    = (alu_ctrl == MULTUac) || (alu_ctrl == MULTac);
        req_div    = (alu_ctrl == DIVUac)  || (alu_ctrl == DIVac);
`else
        req_mul    = (alu_ctrl == MULTUac);
        req_div    = (alu_ctrl == DIVUac);
`endif
        a_load = a;
        b_load = b;
`ifdef MULDIV_SIGNED_EN
        if (req_signed && a[WIDTH-1]) a_load = -a;
        if (req_signed && b[WIDTH-1]) b_load = -b;
`endif
    end

    assign last_step = (count == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM: state register + next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        accept_mul = 1'b0;
        accept_div = 1'b0;
        case (state)
            IDLE, DONE: begin
                // A start in DONE is taken right away; done still pulses
                // for the finished operation because it follows the state.
                accept_mul = start & req_mul;
                accept_div = start & req_div;
                if (accept_mul)      state_nxt = MUL;
                else if (accept_div) state_nxt = DIV;
                else                 state_nxt = IDLE;
            end
            MUL, DIV: begin
                if (last_step) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Arithmetic step
    // ------------------------------------------------------------------
    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .is_div   (state == DIV),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    // Final HI/LO values: acc_next is {product} for multiply and
    // {remainder, quotient} for divide, so the split is identical.
    always_comb begin
        {res_hi, res_lo} = acc_next;
`ifdef MULDIV_SIGNED_EN
        if (state == MUL) begin
            if (neg_q) {res_hi, res_lo} = -acc_next;
        end else begin
            if (neg_q) res_lo = -acc_next[WIDTH-1:0];
            if (neg_r) res_hi = -acc_next[2*WIDTH-1:WIDTH];
        end
`endif
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            hi      <= '0;
            lo      <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
`endif
        end else if (accept_mul || accept_div) begin
            count   <= '0;
            // Multiply: multiplier in the low half, multiplicand aside.
            // Divide:   dividend in the low half, divisor aside.
            acc     <= {{WIDTH{1'b0}}, (accept_mul ? b_load : a_load)};
            operand <= accept_mul ? a_load : b_load;
`ifdef MULDIV_SIGNED_EN
            neg_q   <= req_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r   <= req_signed & a[WIDTH-1];
`endif
        end else if (busy) begin
            acc   <= acc_next;
            count <= count + 1'b1;
            if (last_step) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy  = (state == MUL) || (state == DIV);
    assign done  = (state == DONE);
    assign stall = busy & is_mf(alu_ctrl);

    always_comb begin
        mf_out = '0;
        if (alu_ctrl == MFHIac)      mf_out = hi;
        else if (alu_ctrl == MFLOac) mf_out = lo;
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_muldiv_unit
//   Scoreboard bench for hilo_muldiv_unit. Each accepted request pushes its
//   expected HI/LO (from a plain-arithmetic reference model) into a queue; a
//   monitor pops and compares whenever done pulses, and also checks latency,
//   the done pulse width, stall and the HI/LO read-back.
//   Define MULDIV_SIGNED_EN for both bench and RTL to exercise signed ops.
// -----------------------------------------------------------------------------
module tb_hilo_muldiv_unit;
    import hilo_muldiv_unit_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   alu_ctrl = ADDac;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] mf_out;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    bit   prev_done = 1'b0;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .alu_ctrl (alu_ctrl),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo),
        .mf_out   (mf_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference model: HI/LO straight from integer arithmetic.
    function automatic exp_t model(input logic [3:0] ctrl, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t        e;
        logic [63:0] p;
        longint      sx;
        longint      sy;
        e.hi = '0;
        e.lo = '0;
        e.name = "op";
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (ctrl)
            MULTUac: begin
                p = 64'(x) * 64'(y);
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.name = $sformatf("multu_%0h_%0h", x, y);
            end
            DIVUac: begin
                if (y == 0) begin
                    e.hi = x;
                    e.lo = '1;
                end else begin
                    e.hi = x % y;
                    e.lo = x / y;
                end
                e.name = $sformatf("divu_%0h_%0h", x, y);
            end
            MULTac: begin
                p = 64'(sx * sy);
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.name = $sformatf("mult_%0h_%0h", x, y);
            end
            DIVac: begin
                p = 64'(sx / sy);
                e.lo = p[31:0];
                p = 64'(sx % sy);
                e.hi = p[31:0];
                e.name = $sformatf("div_%0h_%0h", x, y);
            end
            default: ;
        endcase
        return e;
    endfunction

    // Present a start for one cycle; push the expectation if it should be taken.
    task automatic issue(input logic [3:0] ctrl, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit accepted);
        if (accepted) exp_q.push_back(model(ctrl, x, y));
        start    = 1'b1;
        alu_ctrl = ctrl;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        start    = 1'b0;
        alu_ctrl = ADDac;
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < W + 8 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: actual=no done required=done within %0d cycles", W + 8);
        end
    endtask

    task automatic run_op(input logic [3:0] ctrl, input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clk);
        #1;
        issue(ctrl, x, y, 1'b1);
        wait_done();
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (prev_done) check("done_one_cycle", 64'(done), 64'(0));
                if (busy) begin
                    busy_cnt++;
                    if (alu_ctrl == MFHIac || alu_ctrl == MFLOac)
                        check("stall_while_busy", 64'(stall), 64'(1));
                end
                if (done) begin
                    check("stall_in_done", 64'(stall), 64'(0));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: actual=done required=no pending op");
                    end else begin
                        mon_e = exp_q.pop_front();
                        check({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
                        check({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
                        check({mon_e.name, "_latency"}, 64'(busy_cnt), 64'(W));
                        if (alu_ctrl == MFHIac) check("mfhi_in_done", 64'(mf_out), 64'(mon_e.hi));
                        if (alu_ctrl == MFLOac) check("mflo_in_done", 64'(mf_out), 64'(mon_e.lo));
                    end
                    busy_cnt = 0;
                end
                prev_done = done;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [3:0]   ctrl;
        logic [W-1:0] x;
        logic [W-1:0] y;

        repeat (3) @(posedge clk);
        #1;
        alu_ctrl = MFHIac;
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_stall", 64'(stall), 64'(0));
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        check("reset_mf_out", 64'(mf_out), 64'(0));
        alu_ctrl = ADDac;
        rst_n = 1'b1;

        // Directed arithmetic cases
        run_op(MULTUac, 32'd3, 32'd5);
        run_op(MULTUac, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(DIVUac, 32'd100, 32'd7);
        run_op(DIVUac, 32'd5, 32'd0);
        run_op(DIVUac, 32'hFFFF_FFFF, 32'd1);

        // MFHI held through a multiply: stall on every busy cycle, read-back in done
        @(posedge clk);
        #1;
        issue(MULTUac, 32'hFFFF_FFFF, 32'h0000_0003, 1'b1);
        alu_ctrl = MFHIac;
        wait_done();
        @(negedge clk);
        check("stall_idle", 64'(stall), 64'(0));
        check("mfhi_idle", 64'(mf_out), 64'h2);
        alu_ctrl = MFLOac;
        #1;
        check("mflo_idle", 64'(mf_out), 64'hFFFF_FFFD);
        alu_ctrl = ADDac;
        #1;
        check("mf_other_code", 64'(mf_out), 64'(0));

        // start while busy is ignored
        @(posedge clk);
        #1;
        issue(DIVUac, 32'd100, 32'd7, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; alu_ctrl = DIVUac; a = 32'd1; b = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0; alu_ctrl = ADDac;
        wait_done();

        // New start accepted in the done cycle
        #1;
        issue(MULTUac, 32'h1234_5678, 32'h0000_0100, 1'b1);
        wait_done();

        // Reset in the middle of an operation
        @(posedge clk);
        #1;
        issue(MULTUac, 32'd7, 32'd9, 1'b1);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_hi", 64'(hi), 64'(0));
        check("midreset_lo", 64'(lo), 64'(0));
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_op(MULTUac, 32'd2, 32'd2);

        // Unrecognised codes never start an operation
        @(posedge clk);
        #1;
        issue(ORac, 32'd3, 32'd4, 1'b0);
        check("ignored_or_busy", 64'(busy), 64'(0));
        issue(MFHIac, 32'd3, 32'd4, 1'b0);
        check("ignored_mfhi_busy", 64'(busy), 64'(0));
`ifdef MULDIV_SIGNED_EN
        run_op(MULTac, -32'sd3, 32'd5);
        run_op(DIVac, -32'sd7, 32'd2);
        run_op(DIVac, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(MULTac, 32'h8000_0000, 32'h8000_0000);
`else
        issue(MULTac, 32'd3, 32'd5, 1'b0);
        check("ignored_mult_busy", 64'(busy), 64'(0));
        issue(DIVac, 32'd7, 32'd2, 1'b0);
        check("ignored_div_busy", 64'(busy), 64'(0));
`endif

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
`ifdef MULDIV_SIGNED_EN
            case ($urandom_range(3, 0))
                0: ctrl = MULTUac;
                1: ctrl = DIVUac;
                2: ctrl = MULTac;
                default: ctrl = DIVac;
            endcase
`else
            ctrl = ($urandom_range(1, 0) == 0) ? 4'(MULTUac) : 4'(DIVUac);
`endif
            x = $urandom;
            case ($urandom_range(3, 0))
                0: y = 32'($urandom_range(255, 1));
                1: y = (ctrl == DIVUac) ? 32'd0 : $urandom;
                default: y = $urandom;
            endcase
            if (ctrl == DIVac && y == 0) y = 32'd3;
            run_op(ctrl, x, y);
        end

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
